// File: rtl/memory_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: controller modes, sequencer states and requester ids.
package memory_access_sequencer_pkg;

    typedef enum logic [1:0] {
        NOP           = 2'd0,
        LOAD          = 2'd1,
        STORE_PRELOAD = 2'd2,
        STORE         = 2'd3
    } MemoryMode_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCESS    = 3'd1,
        LOAD_DATA = 3'd2,
        WRITE     = 3'd3,
        ABORT     = 3'd4
    } MemorySequencerState_t;

    typedef enum logic {
        CORE  = 1'b0,
        DEBUG = 1'b1
    } RequesterId_t;

    // Controller mode for a given sequencer state; stores always preload first so errors surface before a write.
    function automatic MemoryMode_t sequence_mode(input MemorySequencerState_t st, input logic is_store);
        MemoryMode_t m;
        case (st)
            ACCESS:    m = is_store ? STORE_PRELOAD : LOAD;
            LOAD_DATA: m = LOAD;
            WRITE:     m = STORE;
            default:   m = NOP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_access_sequencer_arbiter.sv
// Two-way round-robin arbiter; lastGrant only advances when the sequencer accepts a request.
module memory_sequencer_arbiter
    import memory_access_sequencer_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         core_req,
    input  logic         debug_req,
    input  logic         accept,
    output RequesterId_t grant
);

    RequesterId_t last_grant_q;
    RequesterId_t last_grant_d;

    // Grant selection and lastGrant update
    always_comb begin
        grant        = CORE;
        last_grant_d = last_grant_q;
        if (core_req && debug_req) begin
            grant = (last_grant_q == CORE) ? DEBUG : CORE;
        end else if (debug_req) begin
            grant = DEBUG;
        end else begin
            grant = CORE;
        end
        if (accept) begin
            last_grant_d = grant;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // lastGrant starts at DEBUG so the core wins the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= DEBUG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/memory_access_sequencer.sv
// Shares the memory controller data port between core and debug agent with a fixed 3-cycle sequence.
// Optional counters enabled by defining MEMORY_SEQUENCER_STATS_EN.
module memory_access_sequencer
    import memory_access_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        coreReq,
    input  logic        coreIsStore,
    input  logic [2:0]  coreFunct3,
    input  logic        debugReq,
    input  logic        debugIsStore,
    input  logic [2:0]  debugFunct3,
    input  logic        memoryUnalignedAccess,
    input  logic        memoryBadFunct3,
    output MemoryMode_t memoryMode,
    output logic [2:0]  funct3,
    output logic        grantDebug,
    output logic        busy,
    output logic        coreDone,
    output logic        debugDone,
    output logic        accessError,
    output logic        errorUnaligned,
    output logic        errorBadFunct3
`ifdef MEMORY_SEQUENCER_STATS_EN
    ,
    output logic [31:0] accessCount,
    output logic [31:0] errorCount
`endif
);

    MemorySequencerState_t state_q, state_d;
    RequesterId_t          grant_q, grant_d;
    RequesterId_t          arb_grant_s;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  err_unaligned_q, err_unaligned_d;
    logic                  err_bad_funct3_q, err_bad_funct3_d;
    logic                  accept_s;
    logic                  done_s;

    assign accept_s = (state_q == IDLE) && (coreReq || debugReq);

    memory_sequencer_arbiter u_arbiter (
        .clock     (clock),
        .reset     (reset),
        .core_req  (coreReq),
        .debug_req (debugReq),
        .accept    (accept_s),
        .grant     (arb_grant_s)
    );

    // Next-state logic; request fields are latched once at grant time
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        is_store_d       = is_store_q;
        funct3_d         = funct3_q;
        err_unaligned_d  = err_unaligned_q;
        err_bad_funct3_d = err_bad_funct3_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d    = ACCESS;
                    grant_d    = arb_grant_s;
                    is_store_d = (arb_grant_s == DEBUG) ? debugIsStore : coreIsStore;
                    funct3_d   = (arb_grant_s == DEBUG) ? debugFunct3 : coreFunct3;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                err_unaligned_d  = memoryUnalignedAccess;
                err_bad_funct3_d = memoryBadFunct3;
                if (memoryUnalignedAccess || memoryBadFunct3) begin
                    state_d = ABORT;
                end else if (is_store_q) begin
                    state_d = WRITE;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_DATA: state_d = IDLE;
            WRITE:     state_d = IDLE;
            ABORT:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            grant_q          <= CORE;
            is_store_q       <= 1'b0;
            funct3_q         <= 3'b000;
            err_unaligned_q  <= 1'b0;
            err_bad_funct3_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            is_store_q       <= is_store_d;
            funct3_q         <= funct3_d;
            err_unaligned_q  <= err_unaligned_d;
            err_bad_funct3_q <= err_bad_funct3_d;
        end
    end

    // Reset masks mode and handshakes so an interrupted WRITE never commits or signals done
    always_comb begin
        done_s         = ((state_q == LOAD_DATA) || (state_q == WRITE) || (state_q == ABORT)) && !reset;
        memoryMode     = reset ? NOP : sequence_mode(state_q, is_store_q);
        funct3         = funct3_q;
        grantDebug     = (grant_q == DEBUG);
        busy           = (state_q != IDLE);
        coreDone       = done_s && (grant_q == CORE);
        debugDone      = done_s && (grant_q == DEBUG);
        accessError    = !reset && (state_q == ABORT);
        errorUnaligned = !reset && (state_q == ABORT) && err_unaligned_q;
        errorBadFunct3 = !reset && (state_q == ABORT) && err_bad_funct3_q;
    end

`ifdef MEMORY_SEQUENCER_STATS_EN
    logic [31:0] access_count_q, access_count_d;
    logic [31:0] error_count_q, error_count_d;

    // Counters wrap naturally at 2^32
    always_comb begin
        access_count_d = access_count_q;
        error_count_d  = error_count_q;
        if ((state_q == LOAD_DATA) || (state_q == WRITE)) begin
            access_count_d = access_count_q + 32'd1;
        end else if (state_q == ABORT) begin
            error_count_d = error_count_q + 32'd1;
        end else begin
            access_count_d = access_count_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clock) begin
        if (reset) begin
            access_count_q <= 32'd0;
            error_count_q  <= 32'd0;
        end else begin
            access_count_q <= access_count_d;
            error_count_q  <= error_count_d;
        end
    end

    assign accessCount = access_count_q;
    assign errorCount  = error_count_q;
`endif

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Self-checking bench: transaction-level reference model checked every cycle plus directed literal checks.
module tb_memory_access_sequencer;
    import memory_access_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        coreReq = 1'b0, coreIsStore = 1'b0;
    logic [2:0]  coreFunct3 = 3'b000;
    logic        debugReq = 1'b0, debugIsStore = 1'b0;
    logic [2:0]  debugFunct3 = 3'b000;
    logic        memoryUnalignedAccess = 1'b0, memoryBadFunct3 = 1'b0;
    MemoryMode_t memoryMode;
    logic [2:0]  funct3;
    logic        grantDebug, busy, coreDone, debugDone;
    logic        accessError, errorUnaligned, errorBadFunct3;
`ifdef MEMORY_SEQUENCER_STATS_EN
    logic [31:0] accessCount, errorCount;
`endif

    memory_access_sequencer dut (
        .clock                 (clock),
        .reset                 (reset),
        .coreReq               (coreReq),
        .coreIsStore           (coreIsStore),
        .coreFunct3            (coreFunct3),
        .debugReq              (debugReq),
        .debugIsStore          (debugIsStore),
        .debugFunct3           (debugFunct3),
        .memoryUnalignedAccess (memoryUnalignedAccess),
        .memoryBadFunct3       (memoryBadFunct3),
        .memoryMode            (memoryMode),
        .funct3                (funct3),
        .grantDebug            (grantDebug),
        .busy                  (busy),
        .coreDone              (coreDone),
        .debugDone             (debugDone),
        .accessError           (accessError),
        .errorUnaligned        (errorUnaligned),
        .errorBadFunct3        (errorBadFunct3)
`ifdef MEMORY_SEQUENCER_STATS_EN
        ,
        .accessCount           (accessCount),
        .errorCount            (errorCount)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction occupies the cycle after its grant (access) and the next (completion).
    int          m_phase = 0;
    logic        m_gnt = 1'b0;
    logic        m_last = 1'b1;
    logic        m_store = 1'b0;
    logic [2:0]  m_f3 = 3'b000;
    logic        m_una = 1'b0, m_bad = 1'b0;
    int          m_acc = 0, m_err = 0;

    always @(negedge clock) begin
        MemoryMode_t e_mode;
        logic e_busy, e_cd, e_dd, e_ae, e_eu, e_eb;
        if (reset) begin
            check("rst_mode", memoryMode, NOP);
            check("rst_core_done", coreDone, 1'b0);
            check("rst_debug_done", debugDone, 1'b0);
            check("rst_access_error", accessError, 1'b0);
        end else begin
            e_mode = NOP; e_busy = 1'b0; e_cd = 1'b0; e_dd = 1'b0;
            e_ae = 1'b0; e_eu = 1'b0; e_eb = 1'b0;
            if (m_phase == 1) begin
                e_busy = 1'b1;
                e_mode = m_store ? STORE_PRELOAD : LOAD;
            end else if (m_phase == 2) begin
                e_busy = 1'b1;
                e_cd = !m_gnt;
                e_dd = m_gnt;
                if (m_una || m_bad) begin
                    e_ae = 1'b1; e_eu = m_una; e_eb = m_bad;
                end else begin
                    e_mode = m_store ? STORE : LOAD;
                end
            end
            check("model_mode", memoryMode, e_mode);
            check("model_busy", busy, e_busy);
            check("model_core_done", coreDone, e_cd);
            check("model_debug_done", debugDone, e_dd);
            check("model_access_error", accessError, e_ae);
            check("model_err_unaligned", errorUnaligned, e_eu);
            check("model_err_badf3", errorBadFunct3, e_eb);
            if (m_phase != 0) begin
                check("model_grant_debug", grantDebug, m_gnt);
                check("model_funct3", funct3, m_f3);
            end
`ifdef MEMORY_SEQUENCER_STATS_EN
            check("model_access_count", accessCount, m_acc);
            check("model_error_count", errorCount, m_err);
`endif
        end
        // advance the model with the inputs the DUT samples at the next edge
        if (reset) begin
            m_phase = 0; m_last = 1'b1; m_acc = 0; m_err = 0;
        end else if (m_phase == 0) begin
            if (coreReq || debugReq) begin
                m_gnt   = (coreReq && debugReq) ? !m_last : debugReq;
                m_last  = m_gnt;
                m_store = m_gnt ? debugIsStore : coreIsStore;
                m_f3    = m_gnt ? debugFunct3 : coreFunct3;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_una = memoryUnalignedAccess;
            m_bad = memoryBadFunct3;
            m_phase = 2;
        end else begin
            if (m_una || m_bad) m_err++;
            else m_acc++;
            m_phase = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    MemoryMode_t seq_r [0:2];
    int          done_at;
    int          store_cycles;
    logic [2:0]  errs_at;
    logic        gd_at;

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // One request from a single requester; records the mode sequence from the request cycle on
    task automatic run_access(input bit dbg, input bit st, input logic [2:0] f3, input bit una, input bit bad);
        @(posedge clock); #1;
        if (dbg) begin debugReq = 1'b1; debugIsStore = st; debugFunct3 = f3; end
        else begin coreReq = 1'b1; coreIsStore = st; coreFunct3 = f3; end
        memoryUnalignedAccess = una;
        memoryBadFunct3 = bad;
        done_at = -1; store_cycles = 0; errs_at = 3'b000; gd_at = 1'b0;
        for (int k = 0; k < 8 && done_at < 0; k++) begin
            @(negedge clock);
            if (k < 3) seq_r[k] = memoryMode;
            if (memoryMode == STORE) store_cycles++;
            if (dbg ? debugDone : coreDone) begin
                done_at = k;
                errs_at = {accessError, errorUnaligned, errorBadFunct3};
                gd_at = grantDebug;
            end
        end
        @(posedge clock); #1;
        coreReq = 1'b0; debugReq = 1'b0;
        memoryUnalignedAccess = 1'b0; memoryBadFunct3 = 1'b0;
    endtask

    int d_who [0:3];
    int d_cyc [0:3];
    int nd;

    initial begin
        do_reset();
        @(negedge clock);
        check("reset_mode", memoryMode, NOP);
        check("reset_funct3", funct3, 3'b000);
        check("reset_grant_debug", grantDebug, 1'b0);
        check("reset_busy", busy, 1'b0);

        // core lw
        run_access(1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        check("lw_mode0", seq_r[0], NOP);
        check("lw_mode1", seq_r[1], LOAD);
        check("lw_mode2", seq_r[2], LOAD);
        check("lw_done_cycle", done_at, 2);
        check("lw_errs", errs_at, 3'b000);
        check("lw_grant_debug", gd_at, 1'b0);

        // debug sb
        run_access(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
        check("sb_mode1", seq_r[1], STORE_PRELOAD);
        check("sb_mode2", seq_r[2], STORE);
        check("sb_done_cycle", done_at, 2);
        check("sb_store_cycles", store_cycles, 1);
        check("sb_grant_debug", gd_at, 1'b1);

        // core sw, unaligned
        run_access(1'b0, 1'b1, 3'b010, 1'b1, 1'b0);
        check("sw_unal_mode1", seq_r[1], STORE_PRELOAD);
        check("sw_unal_mode2", seq_r[2], NOP);
        check("sw_unal_done_cycle", done_at, 2);
        check("sw_unal_store_cycles", store_cycles, 0);
        check("sw_unal_errs", errs_at, 3'b110);

        // both requesters held high after reset
        do_reset();
        @(posedge clock); #1;
        coreReq = 1'b1; coreIsStore = 1'b0; coreFunct3 = 3'b100;
        debugReq = 1'b1; debugIsStore = 1'b1; debugFunct3 = 3'b001;
        nd = 0;
        for (int k = 0; k < 20 && nd < 4; k++) begin
            @(negedge clock);
            if (coreDone || debugDone) begin
                d_who[nd] = debugDone ? 1 : 0;
                d_cyc[nd] = k;
                nd++;
            end
        end
        @(posedge clock); #1;
        coreReq = 1'b0; debugReq = 1'b0;
        check("rr_done_count", nd, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nd) begin
                check("rr_order", d_who[i], i % 2);
                check("rr_cycle", d_cyc[i], 2 + 3 * i);
            end
        end

        // reset asserted during WRITE
        @(posedge clock); #1;
        debugReq = 1'b1; debugIsStore = 1'b1; debugFunct3 = 3'b010;
        done_at = -1;
        for (int k = 0; k < 8 && done_at < 0; k++) begin
            @(negedge clock);
            if (memoryMode == STORE_PRELOAD) done_at = k;
        end
        check("rstw_preload_seen", done_at, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rstw_mode", memoryMode, NOP);
        check("rstw_debug_done", debugDone, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0; debugReq = 1'b0;
        @(negedge clock);
        check("rstw_after_mode", memoryMode, NOP);
        check("rstw_after_busy", busy, 1'b0);
        check("rstw_after_grant", grantDebug, 1'b0);
        check("rstw_after_funct3", funct3, 3'b000);
        check("rstw_after_done", debugDone, 1'b0);

        // three good accesses and one aborted store
        do_reset();
        run_access(1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
        run_access(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        run_access(1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
        run_access(1'b1, 1'b1, 3'b010, 1'b0, 1'b1);
        check("abort_badf3_errs", errs_at, 3'b101);
        @(negedge clock);
`ifdef MEMORY_SEQUENCER_STATS_EN
        check("stats_access_count", accessCount, 32'd3);
        check("stats_error_count", errorCount, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
